bram_mem_arb: RTL and testbench

- Sequencer and arbiter in front of one simple dual-port BRAM instance (1 write port, 1 registered read port, 1-cycle read latency, write-first bypass on same-address read/write).
- Zero-fills the memory after reset.
- Shares the read port between the datapath lookup requester (priority) and the register/config requester; the config requester also owns the write port.
- Sits between the BlueSwitch table pipeline, the register block, and the table BRAM.

---
 rtl/bram_mem_arb.sv | 185 ++++++++++++++++++
 tb/tb_bram_mem_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_mem_arb.sv
// bram_mem_arb: sequencer and arbiter in front of one simple dual-port BRAM
// (one write port, one registered read port with 1-cycle latency and
// write-first bypass).
//
// After reset the whole memory is zero-filled, one word per cycle, and
// INIT_DONE rises. In RUN the read port is shared between the lookup
// requester, which has priority, and the config requester. A config read
// that keeps losing is forced through after STARVE_LIMIT consecutive losses.
// STARVE_LIMIT = 0 gives strict lookup priority. The config requester also
// owns the write port.
//
// Ports:
//   CLK, RESET                      clock, synchronous active-high reset
//   INIT_DONE                       high once the zero-fill has completed
//   LU_REQ/LU_ADDR                  lookup read request, held until LU_ACK
//   LU_ACK                          combinational grant for the lookup
//   LU_VLD/LU_DATA                  lookup data, one cycle after LU_ACK
//   CFG_REQ/CFG_WR/CFG_ADDR/CFG_DIN config request, held until CFG_ACK
//   CFG_ACK/CFG_DOUT                completion pulse and held read data
//   MEM_WR/MEM_ADDR_WR/MEM_DIN      BRAM write port
//   MEM_RD/MEM_ADDR_RD/MEM_DOUT     BRAM read port
//
// Optional feature, controlled by the macro BRAM_MEM_ARB_STATS_EN:
//   When defined, the module adds the outputs STAT_LU_GRANTS and
//   STAT_CFG_FORCED. These are saturating 32-bit counters of lookup grants
//   and of forced config grants.
module bram_mem_arb #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic                  INIT_DONE,
    input  logic                  LU_REQ,
    input  logic [ADDR_WIDTH-1:0] LU_ADDR,
    output logic                  LU_ACK,
    output logic                  LU_VLD,
    output logic [DATA_WIDTH-1:0] LU_DATA,
    input  logic                  CFG_REQ,
    input  logic                  CFG_WR,
    input  logic [ADDR_WIDTH-1:0] CFG_ADDR,
    input  logic [DATA_WIDTH-1:0] CFG_DIN,
    output logic                  CFG_ACK,
    output logic [DATA_WIDTH-1:0] CFG_DOUT,
    output logic                  MEM_WR,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR_WR,
    output logic [DATA_WIDTH-1:0] MEM_DIN,
    output logic                  MEM_RD,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR_RD,
`ifdef BRAM_MEM_ARB_STATS_EN
    output logic [31:0]           STAT_LU_GRANTS,
    output logic [31:0]           STAT_CFG_FORCED,
`endif
    input  logic [DATA_WIDTH-1:0] MEM_DOUT
);

    localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam bit            STARVE_EN  = (STARVE_LIMIT != 0);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
    logic                    init_done_q, init_done_d;
    logic                    lu_vld_q, lu_vld_d;
    logic                    cfg_ack_q, cfg_ack_d;
    logic                    cfg_busy_q, cfg_busy_d;
    logic                    rd_owner_q, rd_owner_d;   // 1: last cycle's read belongs to config
    logic [SW-1:0]           starve_q, starve_d;
    logic [DATA_WIDTH-1:0]   cfg_dout_q, cfg_dout_d;

    logic init_act, run_act;
    logic cfg_wr_go, cfg_rd_pend, force_cfg, cfg_gnt, lu_gnt;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_INIT;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state logic: walk the fill counter once over the whole memory
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (state_q == S_INIT) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == '1) begin
                state_d = S_RUN;
            end
        end
    end

    // Output logic. A cycle with RESET high issues nothing, so an
    // operation caught by reset is never started or acknowledged.
    always_comb begin
        init_act    = (state_q == S_INIT) && !RESET;
        run_act     = (state_q == S_RUN) && !RESET;
        cfg_wr_go   = run_act && CFG_REQ && CFG_WR && !cfg_busy_q;
        cfg_rd_pend = run_act && CFG_REQ && !CFG_WR && !cfg_busy_q;
        force_cfg   = STARVE_EN && (starve_q == STARVE_MAX);
        cfg_gnt     = cfg_rd_pend && (force_cfg || !LU_REQ);
        lu_gnt      = run_act && LU_REQ && !cfg_gnt;

        MEM_WR      = init_act || cfg_wr_go;
        MEM_ADDR_WR = init_act ? fill_q : CFG_ADDR;
        MEM_DIN     = init_act ? '0 : CFG_DIN;
        MEM_RD      = cfg_gnt || lu_gnt;
        MEM_ADDR_RD = cfg_gnt ? CFG_ADDR : LU_ADDR;
        LU_ACK      = lu_gnt;
    end

    // Handshake and arbitration bookkeeping
    always_comb begin
        init_done_d = (state_d == S_RUN);
        lu_vld_d    = lu_gnt;
        cfg_ack_d   = cfg_wr_go || cfg_gnt;
        // Busy covers exactly the ACK cycle, so CFG_REQ is ignored there.
        cfg_busy_d  = cfg_wr_go || cfg_gnt;
        rd_owner_d  = cfg_gnt;
        starve_d    = starve_q;
        if (!cfg_rd_pend || cfg_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        cfg_dout_d  = rd_owner_q ? MEM_DOUT : cfg_dout_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            init_done_q <= 1'b0;
            lu_vld_q    <= 1'b0;
            cfg_ack_q   <= 1'b0;
            cfg_busy_q  <= 1'b0;
            rd_owner_q  <= 1'b0;
            starve_q    <= '0;
            cfg_dout_q  <= '0;
        end else begin
            init_done_q <= init_done_d;
            lu_vld_q    <= lu_vld_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_busy_q  <= cfg_busy_d;
            rd_owner_q  <= rd_owner_d;
            starve_q    <= starve_d;
            cfg_dout_q  <= cfg_dout_d;
        end
    end

    assign INIT_DONE = init_done_q;
    assign LU_VLD    = lu_vld_q && !RESET;
    assign LU_DATA   = MEM_DOUT;
    assign CFG_ACK   = cfg_ack_q && !RESET;
    // Read data is shown straight from the BRAM in the ACK cycle, then held.
    assign CFG_DOUT  = (rd_owner_q && !RESET) ? MEM_DOUT : cfg_dout_q;

`ifdef BRAM_MEM_ARB_STATS_EN
    logic [31:0] stat_lu_q, stat_frc_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stat_lu_q  <= '0;
            stat_frc_q <= '0;
        end else begin
            if (lu_gnt && (stat_lu_q != '1)) begin
                stat_lu_q <= stat_lu_q + 32'd1;
            end
            // Only count grants that actually overrode a pending lookup.
            if (cfg_gnt && force_cfg && LU_REQ && (stat_frc_q != '1)) begin
                stat_frc_q <= stat_frc_q + 32'd1;
            end
        end
    end

    assign STAT_LU_GRANTS  = stat_lu_q;
    assign STAT_CFG_FORCED = stat_frc_q;
`endif

endmodule

// File: tb/tb_bram_mem_arb.sv
// Randomized bench for bram_mem_arb. Two instances run side by side:
// index 0 uses STARVE_LIMIT=4 and index 1 uses STARVE_LIMIT=0. Each instance
// has its own BRAM and its own requesters. A transaction-level reference
// model (memory array, loss count, expected responses) predicts every output.
module tb_bram_mem_arb;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int NCYC  = 3000;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic          rst;
    logic          lu_req    [2];
    logic [AW-1:0] lu_addr   [2];
    logic          cfg_req   [2];
    logic          cfg_wr    [2];
    logic [AW-1:0] cfg_addr  [2];
    logic [DW-1:0] cfg_din   [2];
    logic          init_done [2];
    logic          lu_ack    [2];
    logic          lu_vld    [2];
    logic [DW-1:0] lu_data   [2];
    logic          cfg_ack   [2];
    logic [DW-1:0] cfg_dout  [2];
    logic          mem_wr    [2];
    logic [AW-1:0] mem_waddr [2];
    logic [DW-1:0] mem_din   [2];
    logic          mem_rd    [2];
    logic [AW-1:0] mem_raddr [2];
    logic [DW-1:0] mem_dout  [2];

    bram_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) u_dut_s4 (
        .CLK(clk), .RESET(rst), .INIT_DONE(init_done[0]),
        .LU_REQ(lu_req[0]), .LU_ADDR(lu_addr[0]), .LU_ACK(lu_ack[0]),
        .LU_VLD(lu_vld[0]), .LU_DATA(lu_data[0]),
        .CFG_REQ(cfg_req[0]), .CFG_WR(cfg_wr[0]), .CFG_ADDR(cfg_addr[0]),
        .CFG_DIN(cfg_din[0]), .CFG_ACK(cfg_ack[0]), .CFG_DOUT(cfg_dout[0]),
        .MEM_WR(mem_wr[0]), .MEM_ADDR_WR(mem_waddr[0]), .MEM_DIN(mem_din[0]),
        .MEM_RD(mem_rd[0]), .MEM_ADDR_RD(mem_raddr[0]), .MEM_DOUT(mem_dout[0])
    );

    bram_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) u_dut_s0 (
        .CLK(clk), .RESET(rst), .INIT_DONE(init_done[1]),
        .LU_REQ(lu_req[1]), .LU_ADDR(lu_addr[1]), .LU_ACK(lu_ack[1]),
        .LU_VLD(lu_vld[1]), .LU_DATA(lu_data[1]),
        .CFG_REQ(cfg_req[1]), .CFG_WR(cfg_wr[1]), .CFG_ADDR(cfg_addr[1]),
        .CFG_DIN(cfg_din[1]), .CFG_ACK(cfg_ack[1]), .CFG_DOUT(cfg_dout[1]),
        .MEM_WR(mem_wr[1]), .MEM_ADDR_WR(mem_waddr[1]), .MEM_DIN(mem_din[1]),
        .MEM_RD(mem_rd[1]), .MEM_ADDR_RD(mem_raddr[1]), .MEM_DOUT(mem_dout[1])
    );

    // BRAM environment: registered read, write-first on address match
    for (genvar g = 0; g < 2; g++) begin : g_bram
        logic [DW-1:0] mem [DEPTH];
        always @(posedge clk) begin
            if (mem_wr[g]) mem[mem_waddr[g]] <= mem_din[g];
            if (mem_rd[g]) mem_dout[g] <= (mem_wr[g] && (mem_waddr[g] == mem_raddr[g]))
                                          ? mem_din[g] : mem[mem_raddr[g]];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, per instance
    bit            m_known [2];
    bit            m_init  [2];
    int            m_fill  [2];
    bit            m_done  [2];
    bit            e_luv   [2];
    logic [DW-1:0] e_lud   [2];
    bit            e_ack   [2];
    bit            e_ackrd [2];
    logic [DW-1:0] e_cfgd  [2];
    logic [DW-1:0] m_held  [2];
    int            m_loss  [2];
    logic [DW-1:0] m_mem   [2][DEPTH];
    // This cycle's outcome, used by the requesters to advance
    bit            g_lu    [2];
    bit            g_ack   [2];
    bit            g_crd   [2];

    function automatic int lim_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    task automatic model_step(input int i);
        string         p;
        bit            busy, wr, rdp, cwin, lwin;
        logic [DW-1:0] cur;
        p = (i == 0) ? "lim4" : "lim0";
        g_lu[i]  = 1'b0;
        g_ack[i] = 1'b0;
        g_crd[i] = 1'b0;
        if (rst) begin
            chk_eq($sformatf("%s lu_ack_in_reset", p), 64'(lu_ack[i]), 64'(0));
            chk_eq($sformatf("%s lu_vld_in_reset", p), 64'(lu_vld[i]), 64'(0));
            chk_eq($sformatf("%s cfg_ack_in_reset", p), 64'(cfg_ack[i]), 64'(0));
            m_known[i] = 1'b1;
            m_init[i]  = 1'b1;
            m_fill[i]  = 0;
            m_done[i]  = 1'b0;
            e_luv[i]   = 1'b0;
            e_ack[i]   = 1'b0;
            e_ackrd[i] = 1'b0;
            m_held[i]  = '0;
            m_loss[i]  = 0;
        end else if (m_known[i]) begin
            chk_eq($sformatf("%s init_done", p), 64'(init_done[i]), 64'(m_done[i]));
            chk_eq($sformatf("%s lu_vld", p), 64'(lu_vld[i]), 64'(e_luv[i]));
            if (e_luv[i]) chk_eq($sformatf("%s lu_data", p), 64'(lu_data[i]), 64'(e_lud[i]));
            chk_eq($sformatf("%s cfg_ack", p), 64'(cfg_ack[i]), 64'(e_ack[i]));
            g_ack[i] = e_ack[i];
            cur = (e_ack[i] && e_ackrd[i]) ? e_cfgd[i] : m_held[i];
            chk_eq($sformatf("%s cfg_dout", p), 64'(cfg_dout[i]), 64'(cur));
            m_held[i] = cur;
            if (m_init[i]) begin
                chk_eq($sformatf("%s fill_wr", p), 64'(mem_wr[i]), 64'(1));
                chk_eq($sformatf("%s fill_addr", p), 64'(mem_waddr[i]), 64'(m_fill[i]));
                chk_eq($sformatf("%s fill_din", p), 64'(mem_din[i]), 64'(0));
                chk_eq($sformatf("%s lu_ack_in_init", p), 64'(lu_ack[i]), 64'(0));
                chk_eq($sformatf("%s mem_rd_in_init", p), 64'(mem_rd[i]), 64'(0));
                m_mem[i][m_fill[i]] = '0;
                m_fill[i]++;
                if (m_fill[i] == DEPTH) begin
                    m_init[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
                e_luv[i]   = 1'b0;
                e_ack[i]   = 1'b0;
                e_ackrd[i] = 1'b0;
            end else begin
                // A config op occupies its issue cycle and its ACK cycle.
                busy = e_ack[i];
                wr   = cfg_req[i] && !busy && cfg_wr[i];
                rdp  = cfg_req[i] && !busy && !cfg_wr[i];
                cwin = rdp && (!lu_req[i] || (lim_of(i) != 0 && m_loss[i] == lim_of(i)));
                lwin = lu_req[i] && !cwin;
                chk_eq($sformatf("%s lu_ack", p), 64'(lu_ack[i]), 64'(lwin));
                chk_eq($sformatf("%s mem_wr", p), 64'(mem_wr[i]), 64'(wr));
                if (wr) begin
                    chk_eq($sformatf("%s mem_waddr", p), 64'(mem_waddr[i]), 64'(cfg_addr[i]));
                    chk_eq($sformatf("%s mem_din", p), 64'(mem_din[i]), 64'(cfg_din[i]));
                    m_mem[i][cfg_addr[i]] = cfg_din[i];
                end
                chk_eq($sformatf("%s mem_rd", p), 64'(mem_rd[i]), 64'(lwin || cwin));
                if (lwin) chk_eq($sformatf("%s lu_raddr", p), 64'(mem_raddr[i]), 64'(lu_addr[i]));
                if (cwin) chk_eq($sformatf("%s cfg_raddr", p), 64'(mem_raddr[i]), 64'(cfg_addr[i]));
                m_loss[i]  = (rdp && !cwin) ? m_loss[i] + 1 : 0;
                e_luv[i]   = lwin;
                e_lud[i]   = m_mem[i][lu_addr[i]];
                e_ack[i]   = wr || cwin;
                e_ackrd[i] = cwin;
                e_cfgd[i]  = m_mem[i][cfg_addr[i]];
                g_lu[i]    = lwin;
                g_crd[i]   = cwin;
            end
        end
    endtask

    task automatic drive(input int i, input int p_lu, input int p_cfg, input int p_wr);
        if (!lu_req[i] || g_lu[i]) begin
            lu_req[i]  = (int'($urandom_range(99)) < p_lu);
            lu_addr[i] = AW'($urandom_range(DEPTH - 1));
        end
        if (cfg_req[i] && g_ack[i]) begin
            cfg_req[i] = 1'b0;
        end else if (!cfg_req[i]) begin
            cfg_req[i]  = (int'($urandom_range(99)) < p_cfg);
            cfg_wr[i]   = (int'($urandom_range(99)) < p_wr);
            cfg_addr[i] = AW'($urandom_range(DEPTH - 1));
            cfg_din[i]  = $urandom;
        end
    endtask

    initial begin
        int p_lu, p_cfg, p_wr;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lu_req[i]   = 1'b1;   // held across the whole fill
            lu_addr[i]  = '0;
            cfg_req[i]  = 1'b0;
            cfg_wr[i]   = 1'b0;
            cfg_addr[i] = '0;
            cfg_din[i]  = '0;
            m_known[i]  = 1'b0;
            g_lu[i]     = 1'b0;
            g_ack[i]    = 1'b0;
            g_crd[i]    = 1'b0;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
            @(posedge clk);
            #1;
            if (c < 1000) begin
                p_lu = 50;  p_cfg = 40; p_wr = 50;
            end else if (c < 2000) begin
                // Lookups never pause: starvation and strict priority
                p_lu = 100; p_cfg = 70; p_wr = 20;
            end else begin
                p_lu = 60;  p_cfg = 50; p_wr = 40;
            end
            rst = 1'b0;
            if (c == 999) rst = 1'b1;
            if (c >= 2000) begin
                if ($urandom_range(199) == 0) rst = 1'b1;
                // Reset right after a config read grant must swallow its ACK.
                if (g_crd[0] && $urandom_range(1) == 0) rst = 1'b1;
            end
            for (int i = 0; i < 2; i++) drive(i, p_lu, p_cfg, p_wr);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
